fir_coe_loader: RTL

FIR_COE_LOADER -- requirements
Module: fir_coe_loader

---
 rtl/fir_coe_pkg.sv | 13 +
 rtl/fir_coe_cksum.sv | 28 ++
 rtl/fir_coe_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fir_coe_pkg.sv
// Shared types and constants for the FIR coefficient loader.
package fir_coe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } coe_state_t;

   localparam int CFG_DATA_WDTH = 32;
   localparam int CKSUM_WDTH    = 32;

endpackage

// File: rtl/fir_coe_cksum.sv
// Running modulo-2^32 frame checksum; built only with FIR_COE_CHECKSUM_EN.
module fir_coe_cksum
   import fir_coe_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     acc_en,
   input  logic                     sop,
   input  logic [CFG_DATA_WDTH-1:0] data,
   output logic                     match
);

   logic [CKSUM_WDTH-1:0] sum;
   logic [CKSUM_WDTH-1:0] sum_prev;

   // A sop word restarts the sum, so it sees an empty history.
   assign sum_prev = sop ? '0 : sum;
   assign match    = (sum_prev == data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (acc_en) begin
         sum <= sum_prev + data;
      end
   end

endmodule

// File: rtl/fir_coe_loader.sv
// Double-buffered symmetric-FIR coefficient loader: frames fill a shadow bank,
// committed whole to coe_arr on xvld. FIR_COE_CHECKSUM_EN adds a trailing checksum word.
module fir_coe_loader
   import fir_coe_pkg::*;
#(
   parameter int COE_NUM_HALF = 26,
   parameter int COE_WDTH     = 29
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg_vld,
   input  logic                             cfg_sop,
   input  logic                             cfg_eop,
   input  logic [CFG_DATA_WDTH-1:0]         cfg_data,
   output logic                             cfg_rdy,
   input  logic                             xvld,
   output logic [COE_NUM_HALF*COE_WDTH-1:0] coe_arr,
   output logic                             coe_upd,
   output logic                             load_err,
   output logic                             busy
);

`ifdef FIR_COE_CHECKSUM_EN
   localparam int N_WORDS = COE_NUM_HALF + 1;
`else
   localparam int N_WORDS = COE_NUM_HALF;
`endif
   localparam int CNT_W = $clog2(COE_NUM_HALF + 2);

   coe_state_t             state;
   logic [CNT_W-1:0]       cnt;
   logic [COE_WDTH-1:0]    shadow [COE_NUM_HALF];
   logic [COE_WDTH-1:0]    active [COE_NUM_HALF];

   logic                   accept;
   logic                   in_frame;
   logic                   wr_en;
   logic                   last;
   logic                   cksum_ok;
   logic [CNT_W-1:0]       wr_idx;

   // A sop word always lands at index 0, whether starting or restarting a frame.
   always_comb begin
      accept   = cfg_vld & cfg_rdy;
      in_frame = accept & (cfg_sop | (state == LOAD));
      wr_idx   = cfg_sop ? '0 : cnt;
      last     = (wr_idx == CNT_W'(N_WORDS - 1));
      wr_en    = in_frame & (wr_idx < CNT_W'(COE_NUM_HALF));
   end

`ifdef FIR_COE_CHECKSUM_EN
   fir_coe_cksum u_cksum (
      .clk    (clk),
      .rst    (rst),
      .acc_en (in_frame),
      .sop    (cfg_sop),
      .data   (cfg_data),
      .match  (cksum_ok)
   );
`else
   assign cksum_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         cfg_rdy  <= 1'b1;
         busy     <= 1'b0;
         coe_upd  <= 1'b0;
         load_err <= 1'b0;
         shadow   <= '{default: '0};
         active   <= '{default: '0};
      end else begin
         coe_upd  <= 1'b0;
         load_err <= 1'b0;

         for (int k = 0; k < COE_NUM_HALF; k++) begin
            if (wr_en && (wr_idx == CNT_W'(k))) begin
               shadow[k] <= cfg_data[COE_WDTH-1:0];
            end
         end

         case (state)
            IDLE, LOAD: begin
               if (in_frame) begin
                  if (cfg_eop || last) begin
                     cnt <= '0;
                     if (cfg_eop && last && cksum_ok) begin
                        state   <= PEND;
                        busy    <= 1'b1;
                        cfg_rdy <= 1'b0;
                     end else begin
                        load_err <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cfg_rdy  <= 1'b1;
                     end
                  end else begin
                     cnt     <= wr_idx + CNT_W'(1);
                     state   <= LOAD;
                     busy    <= 1'b1;
                     cfg_rdy <= 1'b1;
                  end
               end
            end
            PEND: begin
               if (xvld) begin
                  active  <= shadow;
                  coe_upd <= 1'b1;
                  state   <= IDLE;
                  busy    <= 1'b0;
                  cfg_rdy <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               busy    <= 1'b0;
               cfg_rdy <= 1'b1;
            end
         endcase
      end
   end

   for (genvar k = 0; k < COE_NUM_HALF; k++) begin : g_coe
      assign coe_arr[COE_WDTH*k +: COE_WDTH] = active[k];
   end

endmodule
